// File: rtl/score_display_bcd_pkg.sv
// score_display_bcd shared types and constants.
// Blank code, converter states and decimal helpers.
package score_display_bcd_pkg;

  localparam logic [3:0] BLANK_CODE = 4'd10;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    FORMAT,
    COMMIT
  } conv_state_t;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/score_display_bcd_if.sv
// score_display_bcd game-logic / display bus.
// Master drives scores and blink, slave returns digits.
interface score_display_bcd_if
  import score_display_bcd_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIGITS = 3,
  parameter int VAL_W  = 10
);
  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH*VAL_W-1:0]    score_in;
  logic [NUM_CH-1:0]          blink_en;
  logic [NUM_CH*DIGITS*4-1:0] digit_code;
  logic [NUM_CH-1:0]          overflow;
  logic                       upd_pulse;
  logic [CH_W-1:0]            upd_ch;

  modport master (
    output score_in, blink_en,
    input  digit_code, overflow,
    input  upd_pulse, upd_ch
  );

  modport slave (
    input  score_in, blink_en,
    output digit_code, overflow,
    output upd_pulse, upd_ch
  );
endinterface

// File: rtl/score_display_bcd_bcd_seq_converter.sv
// Sequential shift-and-add-3 binary to BCD.
// One bit per cycle; done marks the final shift.
module bcd_seq_converter
  import score_display_bcd_pkg::*;
#(
  parameter int VAL_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VAL_W-1:0]      value,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  sat
);
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam logic [31:0] THR = 32'(pow10(DIGITS));

  logic [VAL_W-1:0]    bin;
  logic [CNT_W-1:0]    cnt;
  logic [DIGITS*4-1:0] adj;

  // Add 3 to every nibble >= 5, no carry across nibbles.
  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5)
        adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
  end

  // Snapshot on start, then shift one bit per cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (start) begin
      bin <= value;
      bcd <= '0;
      cnt <= CNT_W'(VAL_W);
      sat <= 32'(value) >= THR;
    end else if (cnt != '0) begin
      {bcd, bin} <= {adj[DIGITS*4-2:0], bin, 1'b0};
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/score_display_bcd.sv
// score_display_bcd: round-robin score formatter.
// Shared BCD converter, blanking, saturation, blink.
module score_display_bcd
  import score_display_bcd_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DIGITS    = 3,
  parameter int VAL_W     = 10,
  parameter int BLINK_DIV = 12_500_000
) (
  input logic             CLOCK_50,
  input logic             reset,
  score_display_bcd_if.slave bus
);
  localparam int CH_W  = ch_width(NUM_CH);
  localparam int DW    = DIGITS * 4;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [DW-1:0] RST_DIG =
    {{(DIGITS-1){BLANK_CODE}}, 4'd0};
  localparam logic [DW-1:0] ALL_BLANK = {DIGITS{BLANK_CODE}};
  localparam logic [DW-1:0] ALL_NINE  = {DIGITS{4'd9}};

  conv_state_t      state;
  logic [CH_W-1:0]  ch;
  logic [DW-1:0]    fmt;
  logic [DW-1:0]    fmt_next;
  logic             fmt_sat;
  logic [VAL_W-1:0] conv_value;
  logic             conv_done;
  logic [DW-1:0]    conv_bcd;
  logic             conv_sat;
  logic             lead;
  logic [BLK_W-1:0] blk_cnt;
  logic             hidden;
  logic [DW-1:0]    committed [NUM_CH];
  logic [DW-1:0]    commit_nx [NUM_CH];

  assign conv_value = bus.score_in[int'(ch)*VAL_W +: VAL_W];

  bcd_seq_converter #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (state == LOAD),
    .value    (conv_value),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .sat      (conv_sat)
  );

  // Leading-zero blanking; digit 0 always shown.
  always_comb begin
    fmt_next = '0;
    lead = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (conv_bcd[d*4 +: 4] != 4'd0) lead = 1'b0;
      fmt_next[d*4 +: 4] = lead ? BLANK_CODE
                                : conv_bcd[d*4 +: 4];
    end
    fmt_next[3:0] = conv_bcd[3:0];
    if (conv_sat) fmt_next = ALL_NINE;
  end

  // Channel scheduler: LOAD, SHIFT, FORMAT, COMMIT.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state         <= LOAD;
      ch            <= '0;
      fmt           <= RST_DIG;
      fmt_sat       <= 1'b0;
      bus.overflow  <= '0;
      bus.upd_pulse <= 1'b0;
      bus.upd_ch    <= '0;
    end else begin
      bus.upd_pulse <= 1'b0;
      unique case (state)
        LOAD: state <= SHIFT;
        SHIFT: if (conv_done) state <= FORMAT;
        FORMAT: begin
          fmt     <= fmt_next;
          fmt_sat <= conv_sat;
          state   <= COMMIT;
        end
        COMMIT: begin
          bus.overflow[ch] <= fmt_sat;
          bus.upd_pulse    <= 1'b1;
          bus.upd_ch       <= ch;
          ch    <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Next committed digits: only the COMMIT channel changes.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      commit_nx[c] = committed[c];
      if (state == COMMIT && ch == CH_W'(c))
        commit_nx[c] = fmt;
    end
  end

  // Committed bank plus registered blink mux.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        committed[c] <= RST_DIG;
        bus.digit_code[c*DW +: DW] <= RST_DIG;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        committed[c] <= commit_nx[c];
        bus.digit_code[c*DW +: DW] <=
          (bus.blink_en[c] && hidden) ? ALL_BLANK
                                      : commit_nx[c];
      end
    end
  end

  // Free-running blink half-period counter.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      blk_cnt <= '0;
      hidden  <= 1'b0;
    end else if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt <= '0;
      hidden  <= ~hidden;
    end else begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_score_display_bcd.sv
// score_display_bcd scoreboard bench.
// Arithmetic reference model, randomized scores.
module tb_score_display_bcd;
  localparam int NUM_CH = 2;
  localparam int DIGITS = 3;
  localparam int VAL_W  = 10;
  localparam int BDIV   = 4;
  localparam int PER    = VAL_W + 3;
  localparam int DW     = DIGITS * 4;
  localparam logic [DW-1:0] ALL_BLANK = {DIGITS{4'd10}};
  localparam logic [DW-1:0] RST_DIG = {{(DIGITS-1){4'd10}}, 4'd0};

  typedef struct {
    int            ch;
    logic [DW-1:0] digits;
    bit            ovf;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b0;

  score_display_bcd_if #(
    .NUM_CH (NUM_CH), .DIGITS (DIGITS), .VAL_W (VAL_W)
  ) bus ();

  score_display_bcd #(
    .NUM_CH (NUM_CH), .DIGITS (DIGITS),
    .VAL_W (VAL_W), .BLINK_DIV (BDIV)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  exp_t          q[$];
  int            edge_cnt = 0;
  logic [NUM_CH-1:0] be_seen = '0;
  logic [DW-1:0] model_disp [NUM_CH];
  logic [NUM_CH-1:0] model_ovf;
  int            tests = 0;
  int            fails = 0;

  function automatic logic [DW-1:0] ref_digits(input int v);
    logic [DW-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (v >= 10**DIGITS) r[d*4 +: 4] = 4'd9;
      else if (d > 0 && v < p) r[d*4 +: 4] = 4'd10;
      else r[d*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic void check(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Model: each LOAD slot predicts the commit it will produce.
  always @(posedge CLOCK_50) begin
    if (reset) begin
      edge_cnt = 0;
      q.delete();
    end else begin
      int c, v;
      exp_t e;
      edge_cnt++;
      be_seen = bus.blink_en;
      if ((edge_cnt - 1) % PER == 0) begin
        c = ((edge_cnt - 1) / PER) % NUM_CH;
        v = int'(bus.score_in[c*VAL_W +: VAL_W]);
        e.ch = c;
        e.digits = ref_digits(v);
        e.ovf = (v >= 10**DIGITS);
        q.push_back(e);
      end
    end
  end

  // Monitor: reset values, pulse timing, commits, display.
  always begin
    bit rst_seen;
    @(negedge CLOCK_50 or posedge reset);
    if (reset && !rst_seen) begin
      rst_seen = 1'b1;
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        model_disp[c] = RST_DIG;
        check("rst_digits", 64'(bus.digit_code[c*DW +: DW]),
              64'(RST_DIG));
      end
      model_ovf = '0;
      check("rst_overflow", 64'(bus.overflow), 64'd0);
      check("rst_upd_pulse", 64'(bus.upd_pulse), 64'd0);
      check("rst_upd_ch", 64'(bus.upd_ch), 64'd0);
    end else if (!reset) begin
      rst_seen = 1'b0;
      if (edge_cnt > 0) begin
        bit hid;
        logic [DW-1:0] ed;
        check("upd_pulse_timing", 64'(bus.upd_pulse),
              64'(edge_cnt % PER == 0));
        if (bus.upd_pulse) begin
          if (q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("upd_ch", 64'(bus.upd_ch), 64'(e.ch));
            model_disp[e.ch] = e.digits;
            model_ovf[e.ch] = e.ovf;
            check("overflow", 64'(bus.overflow), 64'(model_ovf));
          end
        end
        hid = (((edge_cnt - 1) / BDIV) % 2) == 1;
        for (int c = 0; c < NUM_CH; c++) begin
          ed = (be_seen[c] && hid) ? ALL_BLANK : model_disp[c];
          check("digit_code", 64'(bus.digit_code[c*DW +: DW]),
                64'(ed));
        end
      end
    end
  end

  task automatic set_score(input int c, input int v);
    bus.score_in[c*VAL_W +: VAL_W] = VAL_W'(v);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic wait_phase(input int m, input int r);
    for (int i = 0; i < 4 * PER * NUM_CH; i++) begin
      @(negedge CLOCK_50);
      if (edge_cnt % m == r) break;
    end
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    #3 reset = 1'b1;
    cycles(2);
    #3 reset = 1'b0;
  endtask

  int boundary [8] = '{0, 9, 10, 99, 100, 999, 1000, 1023};

  initial begin
    bus.score_in = '0;
    bus.blink_en = '0;
    #2 reset = 1'b1;
    cycles(3);
    #3 reset = 1'b0;
    cycles(3 * PER);

    set_score(0, 7);
    set_score(1, 42);
    cycles(4 * PER);

    set_score(0, 999);
    cycles(2 * NUM_CH * PER);
    set_score(0, 1000);
    cycles(2 * NUM_CH * PER);
    set_score(0, 1023);
    cycles(2 * NUM_CH * PER);

    set_score(0, 123);
    cycles(2 * NUM_CH * PER);
    wait_phase(NUM_CH * PER, 4);
    set_score(0, 456);
    cycles(3 * NUM_CH * PER);

    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 3) == 0)
          set_score(c, boundary[$urandom_range(0, 7)]);
        else
          set_score(c, int'($urandom_range(0, 1023)));
      end
      bus.blink_en = NUM_CH'($urandom_range(0, 3));
      cycles(int'($urandom_range(1, 30)));
    end

    bus.blink_en = 2'b10;
    set_score(0, 5);
    set_score(1, 88);
    cycles(5 * PER);
    bus.blink_en = 2'b00;
    cycles(2 * PER);

    bus.blink_en = 2'b01;
    set_score(0, 314);
    set_score(1, 27);
    wait_phase(PER, 5);
    do_reset();
    cycles(5 * PER);
    bus.blink_en = 2'b00;
    cycles(2 * PER);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
